// File: rtl/dma_2d_job_scheduler.sv
// Round-robin job scheduler for the 2D DMA engine: grants one channel's descriptor,
// validates it, starts both masters together and reports done/error to that channel.
module dma_2d_job_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int CH_IDX_W       = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH*32-1:0]   ch_src_addr,
  input  logic [NUM_CH*32-1:0]   ch_dst_addr,
  input  logic [NUM_CH*32-1:0]   ch_width,
  input  logic [NUM_CH*32-1:0]   ch_height,
  input  logic [NUM_CH*32-1:0]   ch_src_stride,
  input  logic [NUM_CH*32-1:0]   ch_dst_stride,
  output logic [NUM_CH-1:0]      ch_ack,
  output logic [NUM_CH-1:0]      ch_done,
  output logic [NUM_CH-1:0]      ch_err,
  output logic [1:0]             o_err_code,
  output logic                   o_rd_start,
  output logic [31:0]            o_src_addr,
  output logic [31:0]            o_img_width,
  output logic [31:0]            o_img_height,
  output logic [31:0]            o_img_stride,
  input  logic                   i_rd_done,
  output logic                   o_wr_start,
  output logic [31:0]            o_dst_addr,
  output logic [31:0]            o_dst_stride,
  input  logic                   i_wr_done,
  output logic                   o_busy,
  output logic [CH_IDX_W-1:0]    o_active_ch
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, DONE} state_t;

  state_t              state, state_next;
  logic [CH_IDX_W-1:0] rr_ptr, rr_next, winner, ptr_after;
  logic [TO_W-1:0]     to_cnt, cnt_next;
  logic                rd_q, wr_q, rd_edge, wr_edge;
  logic                rd_seen, wr_seen, rd_seen_next, wr_seen_next;
  logic                found, bad, take_job, start_next;
  logic [NUM_CH-1:0]   active_oh, ack_next, done_next, err_next;
  logic [1:0]          code_next;
  int                  idx;

  logic [31:0] src_a [NUM_CH];
  logic [31:0] dst_a [NUM_CH];
  logic [31:0] wid_a [NUM_CH];
  logic [31:0] hgt_a [NUM_CH];
  logic [31:0] sst_a [NUM_CH];
  logic [31:0] dst_s [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign src_a[g] = ch_src_addr[g*32 +: 32];
    assign dst_a[g] = ch_dst_addr[g*32 +: 32];
    assign wid_a[g] = ch_width[g*32 +: 32];
    assign hgt_a[g] = ch_height[g*32 +: 32];
    assign sst_a[g] = ch_src_stride[g*32 +: 32];
    assign dst_s[g] = ch_dst_stride[g*32 +: 32];
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ch_req[CH_IDX_W'(idx)]) begin
        winner = CH_IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign active_oh = ONE_HOT0 << o_active_ch;
  assign ptr_after = (o_active_ch == CH_IDX_W'(NUM_CH - 1)) ? '0 : o_active_ch + 1'b1;
  assign rd_edge   = i_rd_done & ~rd_q;
  assign wr_edge   = i_wr_done & ~wr_q;
  assign o_busy    = (state != IDLE);

  assign bad = (o_img_width == 32'd0) || (o_img_height == 32'd0) ||
               (o_img_width[1:0] != 2'b00) ||
               (o_img_stride < o_img_width) || (o_dst_stride < o_img_width);

  always_comb begin
    state_next   = state;
    rr_next      = rr_ptr;
    cnt_next     = to_cnt;
    rd_seen_next = rd_seen;
    wr_seen_next = wr_seen;
    ack_next     = '0;
    done_next    = '0;
    err_next     = '0;
    code_next    = 2'b00;
    start_next   = 1'b0;
    take_job     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          take_job   = 1'b1;
          ack_next   = ONE_HOT0 << winner;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (bad) begin
          err_next   = active_oh;
          code_next  = 2'b01;
          rr_next    = ptr_after;
          state_next = IDLE;
        end else begin
          start_next   = 1'b1;
          cnt_next     = '0;
          rd_seen_next = 1'b0;
          wr_seen_next = 1'b0;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        rd_seen_next = rd_seen | rd_edge;
        wr_seen_next = wr_seen | wr_edge;
        // Completion wins over a timeout that lands in the same cycle.
        if (rd_seen_next && wr_seen_next) begin
          done_next  = active_oh;
          state_next = DONE;
        end else if (to_cnt == TO_LAST) begin
          err_next   = active_oh;
          code_next  = 2'b10;
          rr_next    = ptr_after;
          state_next = IDLE;
        end else begin
          cnt_next = to_cnt + 1'b1;
        end
      end
      DONE: begin
        rr_next    = ptr_after;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      to_cnt       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      rd_seen      <= 1'b0;
      wr_seen      <= 1'b0;
      ch_ack       <= '0;
      ch_done      <= '0;
      ch_err       <= '0;
      o_err_code   <= 2'b00;
      o_rd_start   <= 1'b0;
      o_wr_start   <= 1'b0;
      o_src_addr   <= '0;
      o_img_width  <= '0;
      o_img_height <= '0;
      o_img_stride <= '0;
      o_dst_addr   <= '0;
      o_dst_stride <= '0;
      o_active_ch  <= '0;
    end else begin
      state      <= state_next;
      rr_ptr     <= rr_next;
      to_cnt     <= cnt_next;
      rd_q       <= i_rd_done;
      wr_q       <= i_wr_done;
      rd_seen    <= rd_seen_next;
      wr_seen    <= wr_seen_next;
      ch_ack     <= ack_next;
      ch_done    <= done_next;
      ch_err     <= err_next;
      o_err_code <= code_next;
      o_rd_start <= start_next;
      o_wr_start <= start_next;
      if (take_job) begin
        o_src_addr   <= src_a[winner];
        o_img_width  <= wid_a[winner];
        o_img_height <= hgt_a[winner];
        o_img_stride <= sst_a[winner];
        o_dst_addr   <= dst_a[winner];
        o_dst_stride <= dst_s[winner];
        o_active_ch  <= winner;
      end
    end
  end

endmodule

// File: tb/tb_dma_2d_job_scheduler.sv
// Directed bench for dma_2d_job_scheduler with a simple read/write master model
// whose done levels rise a programmable number of cycles after each start pulse.
`timescale 1ns/1ps
module tb_dma_2d_job_scheduler;

  localparam int NUM_CH         = 4;
  localparam int CH_IDX_W       = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    ch_req = '0;
  logic [127:0]  ch_src_addr = '0;
  logic [127:0]  ch_dst_addr = '0;
  logic [127:0]  ch_width = '0;
  logic [127:0]  ch_height = '0;
  logic [127:0]  ch_src_stride = '0;
  logic [127:0]  ch_dst_stride = '0;
  logic          i_rd_done = 1'b0;
  logic          i_wr_done = 1'b0;
  logic [3:0]    ch_ack, ch_done, ch_err;
  logic [1:0]    o_err_code;
  logic          o_rd_start, o_wr_start, o_busy;
  logic [31:0]   o_src_addr, o_img_width, o_img_height, o_img_stride;
  logic [31:0]   o_dst_addr, o_dst_stride;
  logic [1:0]    o_active_ch;

  dma_2d_job_scheduler #(
    .NUM_CH(NUM_CH), .CH_IDX_W(CH_IDX_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr),
    .ch_width(ch_width), .ch_height(ch_height),
    .ch_src_stride(ch_src_stride), .ch_dst_stride(ch_dst_stride),
    .ch_ack(ch_ack), .ch_done(ch_done), .ch_err(ch_err), .o_err_code(o_err_code),
    .o_rd_start(o_rd_start), .o_src_addr(o_src_addr), .o_img_width(o_img_width),
    .o_img_height(o_img_height), .o_img_stride(o_img_stride), .i_rd_done(i_rd_done),
    .o_wr_start(o_wr_start), .o_dst_addr(o_dst_addr), .o_dst_stride(o_dst_stride),
    .i_wr_done(i_wr_done), .o_busy(o_busy), .o_active_ch(o_active_ch)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  int cyc = 0;
  int done_cnt[4] = '{0, 0, 0, 0};
  int err_cnt[4]  = '{0, 0, 0, 0};
  int rd_start_cnt = 0, wr_start_cnt = 0, split_cnt = 0;
  int start_cyc = 0, done_cyc = 0, err_cyc = 0, ack_cyc = 0;
  logic [1:0] last_code = 2'b00;
  int grants[$];

  int rd_delay = 4, wr_delay = 4;
  int rd_timer = -1, wr_timer = -1;

  int d0, e0, r0, g0, n;
  int exp_g[5] = '{0, 1, 2, 3, 0};
  int bw[4]  = '{6, 64, 64, 64};
  int bh[4]  = '{4, 0, 4, 4};
  int bs[4]  = '{256, 256, 256, 64};
  int bd[4]  = '{256, 256, 32, 64};
  int bbad[4] = '{1, 1, 1, 0};
  int lrd[3] = '{3, 5, 12};
  int lwr[3] = '{13, 5, 2};
  int llat[3] = '{14, 6, 13};

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int totalDone();
    return done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
  endfunction

  function automatic int totalErr();
    return err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3];
  endfunction

  task automatic setDesc(input int ch, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] w, input logic [31:0] h,
                         input logic [31:0] ss, input logic [31:0] ds);
    ch_src_addr[ch*32 +: 32]   = src;
    ch_dst_addr[ch*32 +: 32]   = dst;
    ch_width[ch*32 +: 32]      = w;
    ch_height[ch*32 +: 32]     = h;
    ch_src_stride[ch*32 +: 32] = ss;
    ch_dst_stride[ch*32 +: 32] = ds;
  endtask

  // Raise one channel's request and hold it until its ack is seen.
  task automatic applyStimulus(input int ch);
    int k;
    ch_req[ch] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ch_ack[ch] && k < 20);
    checkOutput($sformatf("ack_latency_ch%0d", ch), k, 1);
    ch_req[ch] = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while (o_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("idle_reached", o_busy, 1'b0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor and master model, both sampling 1 ns after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (ch_ack[i]) grants.push_back(i);
      done_cnt[i] += int'(ch_done[i]);
      err_cnt[i]  += int'(ch_err[i]);
    end
    if (|ch_ack) ack_cyc = cyc;
    if (|ch_done) done_cyc = cyc;
    if (|ch_err) begin
      err_cyc   = cyc;
      last_code = o_err_code;
    end
    if (o_rd_start) begin
      rd_start_cnt++;
      start_cyc = cyc;
    end
    if (o_wr_start) wr_start_cnt++;
    if (o_rd_start !== o_wr_start) split_cnt++;

    if (reset) begin
      i_rd_done = 1'b0;
      rd_timer  = -1;
    end else if (o_rd_start) begin
      i_rd_done = 1'b0;
      rd_timer  = rd_delay;
    end else if (rd_timer > 0) begin
      rd_timer--;
      if (rd_timer == 0) begin
        i_rd_done = 1'b1;
        rd_timer  = -1;
      end
    end
    if (reset) begin
      i_wr_done = 1'b0;
      wr_timer  = -1;
    end else if (o_wr_start) begin
      i_wr_done = 1'b0;
      wr_timer  = wr_delay;
    end else if (wr_timer > 0) begin
      wr_timer--;
      if (wr_timer == 0) begin
        i_wr_done = 1'b1;
        wr_timer  = -1;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", ch_ack, 4'b0000);
    checkOutput("reset_done", ch_done, 4'b0000);
    checkOutput("reset_err", ch_err, 4'b0000);
    checkOutput("reset_code", o_err_code, 2'b00);
    checkOutput("reset_starts", {o_rd_start, o_wr_start}, 2'b00);
    checkOutput("reset_busy", o_busy, 1'b0);
    checkOutput("reset_desc", {o_src_addr, o_dst_addr}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single valid job on channel 0 with exact cycle positions.
    setDesc(0, 32'h1000, 32'h8000, 64, 4, 256, 256);
    rd_delay = 4; wr_delay = 6;
    d0 = done_cnt[0]; e0 = totalErr(); r0 = rd_start_cnt;
    ch_req = 4'b0001;
    @(negedge clk);
    checkOutput("t1_ack", ch_ack, 4'b0001);
    checkOutput("t1_src", o_src_addr, 32'h1000);
    checkOutput("t1_active", o_active_ch, 2'd0);
    checkOutput("t1_busy", o_busy, 1'b1);
    checkOutput("t1_no_early_start", o_rd_start, 1'b0);
    ch_req = 4'b0000;
    @(negedge clk);
    checkOutput("t1_starts", {o_rd_start, o_wr_start}, 2'b11);
    checkOutput("t1_ack_gone", ch_ack, 4'b0000);
    checkOutput("t1_dst", o_dst_addr, 32'h8000);
    checkOutput("t1_geom", {o_img_width, o_img_height}, {32'd64, 32'd4});
    checkOutput("t1_strides", {o_img_stride, o_dst_stride}, {32'd256, 32'd256});
    @(negedge clk);
    checkOutput("t1_start_pulse", {o_rd_start, o_wr_start}, 2'b00);
    waitIdle(100);
    checkOutput("t1_done_once", done_cnt[0] - d0, 1);
    checkOutput("t1_done_latency", done_cyc - start_cyc, 7);
    checkOutput("t1_no_err", totalErr() - e0, 0);
    checkOutput("t1_one_start", rd_start_cnt - r0, 1);

    // All four channels request continuously: round-robin from reset.
    applyReset();
    for (int c = 0; c < 4; c++) setDesc(c, 32'h2000 + c * 32'h100, 32'h9000 + c * 32'h100, 16, 2, 64, 64);
    rd_delay = 2; wr_delay = 3;
    g0 = grants.size(); d0 = totalDone();
    ch_req = 4'b1111;
    n = 0;
    while (grants.size() - g0 < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    ch_req = 4'b0000;
    checkOutput("rr_grant_count", grants.size() - g0, 5);
    for (int i = 0; i < 5; i++)
      if (g0 + i < grants.size()) checkOutput($sformatf("rr_grant%0d", i), grants[g0 + i], exp_g[i]);
    waitIdle(100);
    checkOutput("rr_done_total", totalDone() - d0, 5);

    // Descriptor validation on channel 1, last entry is the exact-stride boundary.
    rd_delay = 2; wr_delay = 2;
    for (int i = 0; i < 4; i++) begin
      setDesc(1, 32'h4000, 32'hA000, bw[i], bh[i], bs[i], bd[i]);
      d0 = totalDone(); e0 = err_cnt[1]; r0 = rd_start_cnt;
      applyStimulus(1);
      waitIdle(100);
      if (bbad[i] != 0) begin
        checkOutput($sformatf("bad%0d_err", i), err_cnt[1] - e0, 1);
        checkOutput($sformatf("bad%0d_code", i), last_code, 2'b01);
        checkOutput($sformatf("bad%0d_no_start", i), rd_start_cnt - r0, 0);
        checkOutput($sformatf("bad%0d_err_cycle", i), err_cyc - ack_cyc, 1);
        checkOutput($sformatf("bad%0d_no_done", i), totalDone() - d0, 0);
      end else begin
        checkOutput("edge_stride_done", totalDone() - d0, 1);
        checkOutput("edge_stride_no_err", err_cnt[1] - e0, 0);
        checkOutput("edge_stride_start", rd_start_cnt - r0, 1);
      end
    end

    // Done ordering: completion only after the later of the two edges.
    setDesc(2, 32'h5000, 32'hB000, 128, 8, 128, 256);
    for (int i = 0; i < 3; i++) begin
      rd_delay = lrd[i]; wr_delay = lwr[i];
      d0 = done_cnt[2];
      applyStimulus(2);
      waitIdle(100);
      checkOutput($sformatf("order%0d_done_once", i), done_cnt[2] - d0, 1);
      checkOutput($sformatf("order%0d_latency", i), done_cyc - start_cyc, llat[i]);
    end

    // Timeout: write master never finishes.
    setDesc(3, 32'h6000, 32'hC000, 32, 2, 32, 32);
    rd_delay = 3; wr_delay = -1;
    d0 = totalDone(); e0 = err_cnt[3];
    applyStimulus(3);
    waitIdle(100);
    checkOutput("to_err", err_cnt[3] - e0, 1);
    checkOutput("to_code", last_code, 2'b10);
    checkOutput("to_cycle", err_cyc - start_cyc, 16);
    checkOutput("to_no_done", totalDone() - d0, 0);
    rd_delay = 4; wr_delay = 4;
    d0 = done_cnt[0];
    applyStimulus(0);
    waitIdle(100);
    checkOutput("to_next_job_done", done_cnt[0] - d0, 1);

    // Reset in the middle of WAIT.
    setDesc(1, 32'h7000, 32'hD000, 64, 4, 64, 64);
    rd_delay = 20; wr_delay = 20;
    d0 = totalDone(); e0 = totalErr();
    applyStimulus(1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_busy", o_busy, 1'b0);
    checkOutput("mid_reset_pulses", {ch_done, ch_err}, 8'h00);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("mid_reset_no_done", totalDone() - d0, 0);
    checkOutput("mid_reset_no_err", totalErr() - e0, 0);
    rd_delay = 3; wr_delay = 3;
    d0 = done_cnt[2];
    applyStimulus(2);
    waitIdle(100);
    checkOutput("post_reset_job", done_cnt[2] - d0, 1);

    checkOutput("starts_paired", split_cnt, 0);
    checkOutput("start_counts_equal", wr_start_cnt, rd_start_cnt);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
